recovery_fifo_bridge: RTL

Sequential bridge between the I3CCSR external-register port of `I3C_EC.SecFwRecoveryIf.INDIRECT_FIFO_DATA` and the `caliptra_prim_fifo_sync` indirect FIFO. It latches each single-cycle CSR request and performs the FIFO push or pop. It returns a registered `wr_ack`/`rd_ack`, and it maintains write/read indices plus full/empty status for the recovery CSRs. An optional watchdog completes stuck accesses with an error.

---
 rtl/recovery_fifo_bridge.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/recovery_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : recovery_fifo_bridge
// Purpose  : Bridges single-cycle I3C recovery CSR requests on
//            INDIRECT_FIFO_DATA to a synchronous FIFO push/pop handshake.
//            Issues registered acks and tracks push/pop indices and
//            full/empty status for the recovery CSRs.
// Options  : define I3C_RECOVERY_FIFO_TIMEOUT_EN to enable a watchdog that
//            completes a stuck FIFO access with an error and a timeout pulse.
// Revision : 1.0 - initial release
// ============================================================================
module recovery_fifo_bridge #(
   parameter int Depth         = 64,
   parameter int DepthW        = $clog2(Depth) + 1,
   parameter int IdxW          = $clog2(Depth),
   parameter int TimeoutCycles = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              req_is_wr_i,
   input  logic [31:0]       wr_data_i,
   input  logic [31:0]       wr_biten_i,
   output logic              wr_ack_o,
   output logic              rd_ack_o,
   output logic [31:0]       rd_data_o,
   output logic              err_o,
   input  logic              clr_i,
   output logic              fifo_clr_o,
   output logic              fifo_wvalid_o,
   input  logic              fifo_wready_i,
   output logic [31:0]       fifo_wdata_o,
   input  logic              fifo_rvalid_i,
   output logic              fifo_rready_o,
   input  logic [31:0]       fifo_rdata_i,
   input  logic [DepthW-1:0] fifo_depth_i,
   output logic [IdxW-1:0]   wr_index_o,
   output logic [IdxW-1:0]   rd_index_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              timeout_o
);

   // Direction of the outstanding access is carried by the pending state.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_PEND = 2'd1,
      RD_PEND = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t          r_state;
   logic [31:0]     r_data;
   logic            r_wr_ack;
   logic            r_rd_ack;
   logic            r_err;
   logic            r_timeout;
   logic [31:0]     r_rd_data;
   logic            r_clr;
   logic [IdxW-1:0] r_wr_idx;
   logic [IdxW-1:0] r_rd_idx;

   logic            w_wr_hs;
   logic            w_rd_hs;
   logic            w_pending;
   logic            w_wd_fire;

   assign w_pending = (r_state == WR_PEND) || (r_state == RD_PEND);
   assign w_wr_hs   = (r_state == WR_PEND) && fifo_wready_i;
   assign w_rd_hs   = (r_state == RD_PEND) && fifo_rvalid_i;

`ifdef I3C_RECOVERY_FIFO_TIMEOUT_EN
   // Counter wide enough for TimeoutCycles-1, kept within 8..16 bits.
   localparam int c_wd_w = ($clog2(TimeoutCycles) < 8)  ? 8  :
                           ($clog2(TimeoutCycles) > 16) ? 16 : $clog2(TimeoutCycles);
   localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TimeoutCycles - 1);

   logic [c_wd_w-1:0] r_wd_cnt;

   assign w_wd_fire = w_pending && (r_wd_cnt == c_wd_limit);

   // Watchdog: counts cycles spent waiting on the FIFO, zero otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wd_cnt <= '0;
      end else if (w_pending) begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end else begin
         r_wd_cnt <= '0;
      end
   end
`else
   // Without the watchdog the limit has no effect.
   localparam int c_unused_timeout_cycles = TimeoutCycles;
   assign w_wd_fire = 1'b0;
`endif

   // Access sequencer; a clear outranks a handshake, which outranks the watchdog.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_data    <= '0;
         r_wr_ack  <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_wr_ack  <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         r_rd_data <= '0;
         case (r_state)
            IDLE: begin
               if (req_i) begin
                  r_data  <= wr_data_i & wr_biten_i;
                  r_state <= req_is_wr_i ? WR_PEND : RD_PEND;
               end
            end
            WR_PEND: begin
               if (clr_i) begin
                  r_state  <= RESP;
                  r_wr_ack <= 1'b1;
                  r_err    <= 1'b1;
               end else if (fifo_wready_i) begin
                  r_state  <= RESP;
                  r_wr_ack <= 1'b1;
               end else if (w_wd_fire) begin
                  r_state   <= RESP;
                  r_wr_ack  <= 1'b1;
                  r_err     <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            RD_PEND: begin
               if (clr_i) begin
                  r_state  <= RESP;
                  r_rd_ack <= 1'b1;
                  r_err    <= 1'b1;
               end else if (fifo_rvalid_i) begin
                  r_state   <= RESP;
                  r_rd_ack  <= 1'b1;
                  r_rd_data <= fifo_rdata_i;
               end else if (w_wd_fire) begin
                  r_state   <= RESP;
                  r_rd_ack  <= 1'b1;
                  r_err     <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Push/pop indices wrap naturally at the power-of-two depth; clear wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_clr    <= 1'b0;
      end else begin
         r_clr <= clr_i;
         if (clr_i) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
         end else begin
            if (w_wr_hs) r_wr_idx <= r_wr_idx + 1'b1;
            if (w_rd_hs) r_rd_idx <= r_rd_idx + 1'b1;
         end
      end
   end

   assign fifo_wvalid_o = (r_state == WR_PEND);
   assign fifo_wdata_o  = r_data;
   assign fifo_rready_o = (r_state == RD_PEND) && fifo_rvalid_i;
   assign fifo_clr_o    = r_clr;
   assign wr_ack_o      = r_wr_ack;
   assign rd_ack_o      = r_rd_ack;
   assign err_o         = r_err;
   assign rd_data_o     = r_rd_data;
   assign timeout_o     = r_timeout;
   assign wr_index_o    = r_wr_idx;
   assign rd_index_o    = r_rd_idx;
   assign full_o        = (fifo_depth_i == DepthW'(Depth));
   assign empty_o       = (fifo_depth_i == '0);

endmodule
`default_nettype wire
